// File: rtl/rs422_echo_mc.sv
// rs422_echo_mc: CH_NUM independent RS-422 UART channels, each echoing good RX bytes through a FIFO to TX.
// Define RS422_ECHO_PARITY_EN for 8E1 framing (parity checked on RX, generated on TX); default is 8N1.
module rs422_echo_mc #(
    parameter int CH_NUM     = 2,
    parameter int CLK_FRE    = 200,
    parameter int BAUD_RATE  = 115200,
    parameter int FIFO_DEPTH = 16
) (
    input  logic              sys_clk,
    input  logic              rst,
    input  logic [CH_NUM-1:0] rs422_rx,
    output logic [CH_NUM-1:0] rs422_tx,
    input  logic [CH_NUM-1:0] tx_pause,
    input  logic [CH_NUM-1:0] err_clr,
    output logic [CH_NUM-1:0] frame_err,
    output logic [CH_NUM-1:0] overflow
);
    localparam int CYCLE = CLK_FRE * 1000000 / BAUD_RATE;
    localparam int CW = $clog2(CYCLE);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [CW-1:0] BIT_END = CW'(CYCLE - 1);
    localparam logic [CW-1:0] HALF_END = CW'(CYCLE / 2 - 1);
    localparam logic [2:0] S_IDLE = 3'd0, S_START = 3'd1, S_DATA = 3'd2, S_STOP = 3'd4;
`ifdef RS422_ECHO_PARITY_EN
    localparam logic [2:0] S_PAR = 3'd3;
    localparam logic [2:0] S_AFTER = S_PAR;
`else
    localparam logic [2:0] S_AFTER = S_STOP;
`endif

    for (genvar c = 0; c < CH_NUM; c++) begin : g_ch
        logic [2:0]    sync_q, sync_d, rx_st_q, rx_st_d, tx_st_q, tx_st_d;
        logic [CW-1:0] rx_cnt_q, rx_cnt_d, tx_cnt_q, tx_cnt_d;
        logic [2:0]    rx_bit_q, rx_bit_d, tx_bit_q, tx_bit_d;
        logic [7:0]    rx_dat_q, rx_dat_d, tx_sh_q, tx_sh_d, head;
        logic [AW:0]   wp_q, wp_d, rp_q, rp_d;
        logic [7:0]    mem_q [FIFO_DEPTH];
        logic tx_q, tx_d, fe_q, fe_d, ov_q, ov_d;
        logic rx_in, fall, rx_ok, rx_end, tx_end, push, fe_set, full, empty, wr, pop;
`ifdef RS422_ECHO_PARITY_EN
        logic perr_q, perr_d, tx_par_q, tx_par_d;
        assign rx_ok = rx_in & ~perr_q;
`else
        assign rx_ok = rx_in;
`endif
        // sync_q[1] is the synchronized line, sync_q[2] its previous value
        assign rx_in  = sync_q[1];
        assign fall   = sync_q[2] & ~sync_q[1];
        assign rx_end = rx_cnt_q == BIT_END;
        assign tx_end = tx_cnt_q == BIT_END;
        assign full   = (wp_q - rp_q) == (AW+1)'(FIFO_DEPTH);
        assign empty  = wp_q == rp_q;
        assign wr     = push & ~full;
        assign head   = mem_q[rp_q[AW-1:0]];
        assign pop    = ~empty & ~tx_pause[c] & ((tx_st_q == S_IDLE) | ((tx_st_q == S_STOP) & tx_end));
        assign wp_d   = wp_q + (AW+1)'(wr);
        assign rp_d   = rp_q + (AW+1)'(pop);
        assign fe_d   = fe_set | (fe_q & ~err_clr[c]);
        assign ov_d   = (push & full) | (ov_q & ~err_clr[c]);

        always_comb begin
            sync_d   = {sync_q[1:0], rs422_rx[c]};
            rx_st_d  = rx_st_q;
            rx_cnt_d = rx_cnt_q + 1'b1;
            rx_bit_d = rx_bit_q;
            rx_dat_d = rx_dat_q;
            push     = 1'b0;
            fe_set   = 1'b0;
`ifdef RS422_ECHO_PARITY_EN
            perr_d   = perr_q;
`endif
            case (rx_st_q)
                S_IDLE: begin
                    rx_cnt_d = '0;
                    rx_st_d  = fall ? S_START : S_IDLE;
                end
                S_START: if (rx_cnt_q == HALF_END) begin
                    rx_cnt_d = '0;
                    rx_bit_d = '0;
                    rx_st_d  = rx_in ? S_IDLE : S_DATA;
                end
                S_DATA: if (rx_end) begin
                    rx_cnt_d = '0;
                    rx_bit_d = rx_bit_q + 1'b1;
                    rx_dat_d = {rx_in, rx_dat_q[7:1]};
                    rx_st_d  = (rx_bit_q == 3'd7) ? S_AFTER : S_DATA;
                end
`ifdef RS422_ECHO_PARITY_EN
                S_PAR: if (rx_end) begin
                    rx_cnt_d = '0;
                    perr_d   = rx_in ^ (^rx_dat_q);
                    rx_st_d  = S_STOP;
                end
`endif
                S_STOP: if (rx_end) begin
                    push    = rx_ok;
                    fe_set  = ~rx_ok;
                    rx_st_d = S_IDLE;
                end
                default: rx_st_d = S_IDLE;
            endcase
        end

        always_comb begin
            tx_st_d  = tx_st_q;
            tx_cnt_d = tx_cnt_q + 1'b1;
            tx_bit_d = tx_bit_q;
            tx_sh_d  = tx_sh_q;
            tx_d     = (tx_st_q == S_START) ? 1'b0 : (tx_st_q == S_DATA) ? tx_sh_q[0] : 1'b1;
`ifdef RS422_ECHO_PARITY_EN
            tx_par_d = tx_par_q;
            if (tx_st_q == S_PAR) tx_d = tx_par_q;
`endif
            case (tx_st_q)
                S_IDLE: tx_cnt_d = '0;
                S_START: if (tx_end) begin
                    tx_cnt_d = '0;
                    tx_bit_d = '0;
                    tx_st_d  = S_DATA;
                end
                S_DATA: if (tx_end) begin
                    tx_cnt_d = '0;
                    tx_bit_d = tx_bit_q + 1'b1;
                    tx_sh_d  = {1'b0, tx_sh_q[7:1]};
                    tx_st_d  = (tx_bit_q == 3'd7) ? S_AFTER : S_DATA;
                end
`ifdef RS422_ECHO_PARITY_EN
                S_PAR: if (tx_end) begin
                    tx_cnt_d = '0;
                    tx_st_d  = S_STOP;
                end
`endif
                S_STOP: if (tx_end) begin
                    tx_cnt_d = '0;
                    tx_st_d  = S_IDLE;
                end
                default: tx_st_d = S_IDLE;
            endcase
            // chaining straight from STOP into START keeps back-to-back frames gapless
            if (pop) begin
                tx_st_d  = S_START;
                tx_cnt_d = '0;
                tx_sh_d  = head;
`ifdef RS422_ECHO_PARITY_EN
                tx_par_d = ^head;
`endif
            end
        end

        always_ff @(posedge sys_clk) begin
            if (rst) begin
                sync_q   <= '1;
                rx_st_q  <= S_IDLE;
                rx_cnt_q <= '0;
                rx_bit_q <= '0;
                rx_dat_q <= '0;
                tx_st_q  <= S_IDLE;
                tx_cnt_q <= '0;
                tx_bit_q <= '0;
                tx_sh_q  <= '0;
                tx_q     <= 1'b1;
                wp_q     <= '0;
                rp_q     <= '0;
                fe_q     <= 1'b0;
                ov_q     <= 1'b0;
`ifdef RS422_ECHO_PARITY_EN
                perr_q   <= 1'b0;
                tx_par_q <= 1'b0;
`endif
            end else begin
                sync_q   <= sync_d;
                rx_st_q  <= rx_st_d;
                rx_cnt_q <= rx_cnt_d;
                rx_bit_q <= rx_bit_d;
                rx_dat_q <= rx_dat_d;
                tx_st_q  <= tx_st_d;
                tx_cnt_q <= tx_cnt_d;
                tx_bit_q <= tx_bit_d;
                tx_sh_q  <= tx_sh_d;
                tx_q     <= tx_d;
                wp_q     <= wp_d;
                rp_q     <= rp_d;
                fe_q     <= fe_d;
                ov_q     <= ov_d;
`ifdef RS422_ECHO_PARITY_EN
                perr_q   <= perr_d;
                tx_par_q <= tx_par_d;
`endif
            end
        end

        always_ff @(posedge sys_clk) begin
            if (wr) mem_q[wp_q[AW-1:0]] <= rx_dat_q;
        end

        assign rs422_tx[c]  = tx_q;
        assign frame_err[c] = fe_q;
        assign overflow[c]  = ov_q;
    end
endmodule

// File: tb/tb_rs422_echo_mc.sv
// tb_rs422_echo_mc: randomized echo checks against a frame-level model, with a line monitor decoding TX.
module tb_rs422_echo_mc;
    localparam int CF = 24, BR = 1000000, DEPTH = 4;
    localparam int C = CF * 1000000 / BR;

    logic       clk = 1'b0, rst = 1'b1;
    logic [1:0] rx, tx, fe, ov;
    logic [1:0] pause = 2'b00, clr = 2'b00;
    logic       rx_l [2];
    int         cyc = 0, checks = 0, fails = 0;

    typedef struct {int ch; logic [7:0] b; int t; bit ok;} rec_t;
    rec_t got[$];

    assign rx = {rx_l[1], rx_l[0]};
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    rs422_echo_mc #(.CH_NUM(2), .CLK_FRE(CF), .BAUD_RATE(BR), .FIFO_DEPTH(DEPTH)) dut (
        .sys_clk(clk), .rst(rst), .rs422_rx(rx), .rs422_tx(tx),
        .tx_pause(pause), .err_clr(clr), .frame_err(fe), .overflow(ov));

    // Decodes every TX frame; a bit must hold one level for exactly C clocks.
    task automatic mon(input int ch);
        rec_t r;
        logic v;
        forever begin
            @(negedge clk);
            if (!rst && tx[ch] === 1'b0) begin
                r.ch = ch; r.t = cyc; r.ok = 1'b1; r.b = 8'h00; v = 1'b0;
                for (int i = 0; i < 10; i++) begin
                    for (int j = 0; j < C; j++) begin
                        if (i != 0 || j != 0) @(negedge clk);
                        if (j == 0) v = tx[ch];
                        else if (tx[ch] !== v) r.ok = 1'b0;
                    end
                    if (i == 9 && v !== 1'b1) r.ok = 1'b0;
                    if (i >= 1 && i <= 8) r.b[i-1] = v;
                end
                got.push_back(r);
            end
        end
    endtask

    task automatic send(input int ch, input logic [7:0] b, input bit stop_ok);
        logic [9:0] f;
        f = {1'(stop_ok), b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rx_l[ch] = f[i];
            repeat (C) @(negedge clk);
        end
        rx_l[ch] = 1'b1;
        repeat (2 * C) @(negedge clk);
    endtask

    function automatic int cnt(input int ch);
        int n = 0;
        foreach (got[i]) if (got[i].ch == ch) n++;
        return n;
    endfunction

    function automatic rec_t nth(input int ch, input int k);
        rec_t r;
        int n = 0;
        r = '{default: 0};
        foreach (got[i]) if (got[i].ch == ch) begin
            if (n == k) r = got[i];
            n++;
        end
        return r;
    endfunction

    task automatic wait_n(input int ch, input int n, input int budget);
        for (int i = 0; i < budget && cnt(ch) < n; i++) @(negedge clk);
    endtask

    task automatic test_reset();
        int bad = 0;
        rst = 1'b1;
        for (int i = 0; i < 5; i++) begin
            rx_l[0] = 1'($urandom); rx_l[1] = 1'($urandom);
            @(negedge clk);
        end
        checks++; if (tx !== 2'b11) begin fails++; $display("FAIL reset_tx got %b exp 11", tx); end
        checks++; if (fe !== 2'b00) begin fails++; $display("FAIL reset_fe got %b exp 00", fe); end
        checks++; if (ov !== 2'b00) begin fails++; $display("FAIL reset_ov got %b exp 00", ov); end
        rx_l[0] = 1'b1; rx_l[1] = 1'b1; rst = 1'b0;
        repeat (2000) begin
            @(negedge clk);
            if (tx !== 2'b11 || fe !== 2'b00 || ov !== 2'b00) bad++;
        end
        checks++; if (bad != 0 || got.size() != 0) begin fails++; $display("FAIL reset_idle got %0d bad cycles %0d frames exp 0 0", bad, got.size()); end
    endtask

    task automatic test_single_echo();
        logic [7:0] bs [2];
        rec_t r;
        int n;
        bs[0] = 8'h55; bs[1] = 8'($urandom);
        for (int k = 0; k < 2; k++) begin
            got.delete();
            n = cyc;
            send(0, bs[k], 1'b1);
            wait_n(0, 1, 20 * C);
            repeat (12 * C) @(negedge clk);
            r = nth(0, 0);
            checks++; if (cnt(0) != 1) begin fails++; $display("FAIL single_count got %0d exp 1", cnt(0)); end
            checks++; if (r.b !== bs[k] || !r.ok) begin fails++; $display("FAIL single_byte got %h ok %0d exp %h ok 1", r.b, r.ok, bs[k]); end
            checks++; if (r.t - n < C/2 + 9*C || r.t - n > C/2 + 9*C + 8) begin fails++; $display("FAIL single_latency got %0d exp %0d..%0d", r.t - n, C/2 + 9*C, C/2 + 9*C + 8); end
            checks++; if (cnt(1) != 0 || fe !== 2'b00 || ov !== 2'b00) begin fails++; $display("FAIL single_quiet got ch1 %0d fe %b ov %b exp 0 00 00", cnt(1), fe, ov); end
        end
    endtask

    task automatic test_concurrent();
        logic [7:0] a, b;
        rec_t r0, r1;
        int off;
        for (int k = 0; k < 2; k++) begin
            a = (k == 0) ? 8'hA5 : 8'($urandom);
            b = (k == 0) ? 8'h3C : 8'($urandom);
            off = (k == 0) ? C / 6 : $urandom_range(1, 3 * C);
            got.delete();
            fork
                send(0, a, 1'b1);
                begin repeat (off) @(negedge clk); send(1, b, 1'b1); end
            join
            wait_n(0, 1, 20 * C);
            wait_n(1, 1, 20 * C);
            repeat (12 * C) @(negedge clk);
            r0 = nth(0, 0); r1 = nth(1, 0);
            checks++; if (cnt(0) != 1 || r0.b !== a || !r0.ok) begin fails++; $display("FAIL conc_ch0 got n %0d byte %h exp n 1 byte %h", cnt(0), r0.b, a); end
            checks++; if (cnt(1) != 1 || r1.b !== b || !r1.ok) begin fails++; $display("FAIL conc_ch1 got n %0d byte %h exp n 1 byte %h", cnt(1), r1.b, b); end
            checks++; if (fe !== 2'b00 || ov !== 2'b00) begin fails++; $display("FAIL conc_flags got fe %b ov %b exp 00 00", fe, ov); end
        end
    endtask

    task automatic test_frame_err();
        got.delete();
        send(1, 8'h81, 1'b0);
        repeat (12 * C) @(negedge clk);
        checks++; if (got.size() != 0) begin fails++; $display("FAIL ferr_no_echo got %0d frames exp 0", got.size()); end
        checks++; if (fe !== 2'b10 || ov !== 2'b00) begin fails++; $display("FAIL ferr_flag got fe %b ov %b exp 10 00", fe, ov); end
        clr = 2'b10;
        @(negedge clk);
        clr = 2'b00;
        checks++; if (fe !== 2'b00) begin fails++; $display("FAIL ferr_clear got %b exp 00", fe); end
    endtask

    task automatic test_false_start();
        logic [7:0] b;
        rec_t r;
        got.delete();
        rx_l[0] = 1'b0;
        repeat (C / 4) @(negedge clk);
        rx_l[0] = 1'b1;
        repeat (12 * C) @(negedge clk);
        checks++; if (got.size() != 0 || fe !== 2'b00 || ov !== 2'b00 || tx !== 2'b11) begin fails++; $display("FAIL false_start got frames %0d fe %b ov %b tx %b exp 0 00 00 11", got.size(), fe, ov, tx); end
        b = 8'($urandom);
        send(0, b, 1'b1);
        wait_n(0, 1, 20 * C);
        r = nth(0, 0);
        checks++; if (cnt(0) != 1 || r.b !== b) begin fails++; $display("FAIL false_recover got n %0d byte %h exp n 1 byte %h", cnt(0), r.b, b); end
        repeat (2 * C) @(negedge clk);
    endtask

    task automatic test_overflow();
        logic [7:0] exp[$];
        logic [1:0] ov_exp = 2'b00;
        rec_t r, p;
        got.delete();
        pause = 2'b01;
        for (int k = 1; k <= 5; k++) begin
            send(0, 8'(k), 1'b1);
            if (exp.size() < DEPTH) exp.push_back(8'(k));
            else ov_exp = 2'b01;
        end
        checks++; if (ov !== ov_exp) begin fails++; $display("FAIL ovf_flag got %b exp %b", ov, ov_exp); end
        checks++; if (got.size() != 0) begin fails++; $display("FAIL ovf_paused got %0d frames exp 0", got.size()); end
        pause = 2'b00;
        wait_n(0, exp.size(), 12 * C * DEPTH);
        repeat (12 * C) @(negedge clk);
        checks++; if (cnt(0) != exp.size() || cnt(1) != 0) begin fails++; $display("FAIL ovf_count got %0d/%0d exp %0d/0", cnt(0), cnt(1), exp.size()); end
        foreach (exp[k]) begin
            r = nth(0, k);
            checks++; if (r.b !== exp[k] || !r.ok) begin fails++; $display("FAIL ovf_byte%0d got %h ok %0d exp %h ok 1", k, r.b, r.ok, exp[k]); end
            if (k > 0) begin
                p = nth(0, k - 1);
                checks++; if (r.t - p.t != 10 * C) begin fails++; $display("FAIL ovf_gap%0d got %0d exp %0d", k, r.t - p.t, 10 * C); end
            end
        end
        clr = 2'b01;
        @(negedge clk);
        clr = 2'b00;
        checks++; if (ov !== 2'b00) begin fails++; $display("FAIL ovf_clear got %b exp 00", ov); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp[$];
        logic [7:0] b;
        logic [1:0] fe_exp = 2'b00;
        bit ok;
        int ch, oc;
        rec_t r;
        got.delete();
        ch = $urandom_range(0, 1);
        oc = 1 - ch;
        for (int k = 0; k < 6; k++) begin
            b = 8'($urandom);
            ok = (k == 2) ? 1'b0 : ($urandom_range(0, 3) != 0);
            send(ch, b, ok);
            if (ok) exp.push_back(b);
            else fe_exp[ch] = 1'b1;
        end
        wait_n(ch, exp.size(), 30 * C);
        repeat (12 * C) @(negedge clk);
        checks++; if (cnt(ch) != exp.size() || cnt(oc) != 0) begin fails++; $display("FAIL b2b_count got %0d/%0d exp %0d/0", cnt(ch), cnt(oc), exp.size()); end
        foreach (exp[k]) begin
            r = nth(ch, k);
            checks++; if (r.b !== exp[k] || !r.ok) begin fails++; $display("FAIL b2b_byte%0d got %h ok %0d exp %h ok 1", k, r.b, r.ok, exp[k]); end
        end
        checks++; if (fe !== fe_exp || ov !== 2'b00) begin fails++; $display("FAIL b2b_flags got fe %b ov %b exp %b 00", fe, ov, fe_exp); end
        clr = 2'b11;
        @(negedge clk);
        clr = 2'b00;
    endtask

    initial begin
        repeat (100000) @(posedge clk);
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1);
    end

    initial begin
        rx_l[0] = 1'b1;
        rx_l[1] = 1'b1;
        fork
            mon(0);
            mon(1);
        join_none
        test_reset();
        test_single_echo();
        test_concurrent();
        test_frame_err();
        test_false_start();
        test_overflow();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
